// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and types for the forwarding / hazard-control block.
// Select codes are 0 for "no forward" and k+1 for forwarding stage k.
package hazard_scoreboard_unit_pkg;

  localparam int NUM_FWD_DEF = 3;
  localparam int FWD_SEL_W   = $clog2(NUM_FWD_DEF + 1);

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = '0;
  localparam int       REG_ZERO = 0;

  function automatic int fwd_sel_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_ll_scoreboard.sv
// Long-latency op tracker: per-register pending bits, outstanding-op counter
// and the busy flag used for the structural hazard.
module hazard_scoreboard_unit_ll_scoreboard
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int LL_MAX_OUT = 2,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ll_issue,
  input  logic [REG_AW-1:0]   ll_issue_rd,
  input  logic                ll_done,
  input  logic [REG_AW-1:0]   ll_done_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                ll_busy
);

  localparam int CW = $clog2(LL_MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LL_MAX_OUT);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    // Clear first so that a same-cycle set of the same register wins.
    if (ll_done) pending_d[ll_done_rd] = 1'b0;
    if (ll_issue && ll_issue_rd != REG_AW'(REG_ZERO)) pending_d[ll_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    case ({ll_issue, ll_done})
      2'b10:   if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending = pending_q;
  assign ll_busy = ~rst & (cnt_q == CNT_MAX);

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(ll_issue && !ll_done && cnt_q == CNT_MAX));
  a_no_done_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(ll_done && !ll_issue && cnt_q == '0));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Operand forwarding select, load-use / LL RAW / LL WAW / structural hazard
// detection, ID stall + EX bubble generation and a saturating stall counter.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = 3,
  parameter int NUM_REGS   = 32,
  parameter int LL_MAX_OUT = 2,
  parameter int CNT_W      = 32,
  localparam int REG_AW    = $clog2(NUM_REGS),
  localparam int SEL_W     = fwd_sel_width(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_is_ll,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_is_load,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic                      ll_issue,
  input  logic                      ll_done,
  input  logic [REG_AW-1:0]         ll_done_rd,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [NUM_REGS-1:0]       pending,
  output logic                      ll_busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  logic [NUM_SRC-1:0] src_haz;
  logic               waw_haz, struct_haz, stall;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  hazard_scoreboard_unit_ll_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .LL_MAX_OUT(LL_MAX_OUT)
  ) u_ll_sb (
    .clk        (clk),
    .rst        (rst),
    .ll_issue   (ll_issue),
    .ll_issue_rd(ex_rd),
    .ll_done    (ll_done),
    .ll_done_rd (ll_done_rd),
    .pending    (pending),
    .ll_busy    (ll_busy)
  );

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [SEL_W-1:0]  sel;
    logic [REG_AW-1:0] ers, irs;
    logic              load_use, raw_ll;

    assign ers = ex_rs[gi*REG_AW +: REG_AW];
    assign irs = id_rs[gi*REG_AW +: REG_AW];

    // Scan oldest to youngest so the youngest matching stage overwrites.
    always_comb begin
      sel = SEL_W'(FWD_NONE);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_we[k] && fwd_rd[k*REG_AW +: REG_AW] != RZ &&
            fwd_rd[k*REG_AW +: REG_AW] == ers)
          sel = SEL_W'(k + 1);
      end
    end
    assign fwd_sel[gi*SEL_W +: SEL_W] = rst ? SEL_W'(FWD_NONE) : sel;

    assign load_use = ex_is_load & ex_reg_write & (ex_rd != RZ) &
                      (ex_rd == irs) & id_rs_used[gi];
    assign raw_ll   = id_rs_used[gi] & (irs != RZ) &
                      (pending[irs] | (ll_issue & (ex_rd == irs)));
    assign src_haz[gi] = load_use | raw_ll;
  end

  assign waw_haz    = id_reg_write & (id_rd != RZ) &
                      (pending[id_rd] | (ll_issue & (ex_rd == id_rd)));
  assign struct_haz = id_is_ll & ll_busy;

  assign stall     = (|src_haz | waw_haz | struct_haz) & id_valid & ~flush & ~rst;
  assign stall_id  = stall;
  assign bubble_ex = stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
